// File: rtl/memory_stage_lsu.sv
// Memory stage: load/store unit with req/ack data-memory port,
// lane alignment, load extension, exceptions and MEM/WB register.
module memory_stage_lsu #(
  parameter int DATA_WIDTH     = 64,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int TIMEOUT        = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      valid_m_i,
  input  logic                      reg_write_m_i,
  input  logic [1:0]                result_src_m_i,
  input  logic                      mem_read_m_i,
  input  logic                      mem_write_m_i,
  input  logic [2:0]                funct3_m_i,
  input  logic [DATA_WIDTH-1:0]     alu_result_m_i,
  input  logic [DATA_WIDTH-1:0]     rs2_data_m_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_m_i,
  input  logic [DATA_WIDTH-1:0]     pc_plus_4_m_i,
  output logic                      stall_m_o,
  output logic                      dmem_req_o,
  output logic                      dmem_we_o,
  output logic [DATA_WIDTH-1:0]     dmem_addr_o,
  output logic [DATA_WIDTH-1:0]     dmem_wdata_o,
  output logic [DATA_WIDTH/8-1:0]   dmem_be_o,
  input  logic                      dmem_ack_i,
  input  logic [DATA_WIDTH-1:0]     dmem_rdata_i,
  output logic                      valid_w_o,
  output logic                      reg_write_w_o,
  output logic [1:0]                result_src_w_o,
  output logic [DATA_WIDTH-1:0]     read_data_w_o,
  output logic [DATA_WIDTH-1:0]     alu_result_w_o,
  output logic [REG_ADDR_WIDTH-1:0] rd_addr_w_o,
  output logic [DATA_WIDTH-1:0]     pc_plus_4_w_o,
  output logic                      exc_w_o,
  output logic [1:0]                exc_cause_w_o
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int OW = $clog2(NB);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  typedef struct packed {
    logic                      valid;
    logic                      reg_write;
    logic [1:0]                result_src;
    logic [DATA_WIDTH-1:0]     read_data;
    logic [DATA_WIDTH-1:0]     alu_result;
    logic [REG_ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0]     pc_plus_4;
    logic                      exc;
    logic [1:0]                cause;
  } mem_wb_t;

  state_t          state;
  state_t          state_n;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_n;

  logic [OW-1:0]   offset;
  logic [1:0]      size_log;
  logic [OW-1:0]   amask;
  logic            too_big;
  logic            misaligned;
  logic            mem_op;
  logic            aligned_op;
  logic            mis_exc;
  logic            fire;
  logic            req;
  logic            stall;
  logic            exc;
  logic [1:0]      cause;

  logic [NB-1:0]         be_mask;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] lmask;
  logic                  sbit;
  logic [DATA_WIDTH-1:0] ext;

  mem_wb_t wb_d;
  mem_wb_t wb_q;

  assign offset   = alu_result_m_i[OW-1:0];
  assign size_log = funct3_m_i[1:0];
  assign too_big  = int'(size_log) > OW;
  assign mem_op   = valid_m_i
                  & (mem_read_m_i | mem_write_m_i);

  always_comb begin
    amask = '0;
    unique case (size_log)
      2'd0:    amask = '0;
      2'd1:    amask = OW'(1);
      2'd2:    amask = OW'(3);
      default: amask = OW'(7);
    endcase
  end

  assign misaligned = too_big | (|(offset & amask));
  assign aligned_op = mem_op & ~misaligned;
  assign mis_exc    = mem_op & misaligned;

  // Ack with the request still pending beats a same-cycle timeout.
  assign fire = (TIMEOUT != 0)
              & (state == S_WAIT)
              & (count == LAST)
              & aligned_op
              & ~dmem_ack_i;

  assign req   = rst_n & aligned_op;
  assign stall = req & ~dmem_ack_i & ~fire;

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:
        if (aligned_op && !dmem_ack_i)
          state_n = S_WAIT;
      S_WAIT:
        if (!aligned_op || dmem_ack_i || fire)
          state_n = S_IDLE;
      default:
        state_n = S_IDLE;
    endcase
  end

  always_comb begin
    count_n = '0;
    if (state == S_WAIT && state_n == S_WAIT)
      count_n = count + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      count <= '0;
    end else begin
      state <= state_n;
      count <= count_n;
    end
  end

  always_comb begin
    be_mask = '0;
    unique case (size_log)
      2'd0:    be_mask = NB'(8'h01);
      2'd1:    be_mask = NB'(8'h03);
      2'd2:    be_mask = NB'(8'h0F);
      default: be_mask = NB'(8'hFF);
    endcase
  end

  assign stall_m_o  = stall;
  assign dmem_req_o = req;
  assign dmem_we_o  = req & mem_write_m_i;

  assign dmem_addr_o = req
    ? {alu_result_m_i[DATA_WIDTH-1:OW], {OW{1'b0}}}
    : '0;

  assign dmem_be_o = req ? (be_mask << offset) : '0;

  assign dmem_wdata_o = req
    ? (rs2_data_m_i << {offset, 3'b000})
    : '0;

  assign shifted = dmem_rdata_i >> {offset, 3'b000};

  always_comb begin
    lmask = '1;
    sbit  = 1'b0;
    unique case (size_log)
      2'd0: begin
        lmask = DATA_WIDTH'(8'hFF);
        sbit  = shifted[7];
      end
      2'd1: begin
        lmask = DATA_WIDTH'(16'hFFFF);
        sbit  = shifted[15];
      end
      2'd2: begin
        lmask = DATA_WIDTH'(32'hFFFF_FFFF);
        sbit  = shifted[31];
      end
      default: begin
        lmask = '1;
        sbit  = shifted[DATA_WIDTH-1];
      end
    endcase
  end

  // funct3[2] selects the unsigned load variants.
  assign ext = (shifted & lmask)
             | ((~funct3_m_i[2] & sbit) ? ~lmask : '0);

  always_comb begin
    cause = 2'b00;
    unique case (1'b1)
      fire:                     cause = 2'b11;
      mis_exc & mem_write_m_i:  cause = 2'b10;
      mis_exc & ~mem_write_m_i: cause = 2'b01;
      default:                  cause = 2'b00;
    endcase
  end

  assign exc = fire | mis_exc;

  always_comb begin
    wb_d = '0;
    if (!stall) begin
      wb_d.valid      = valid_m_i;
      wb_d.reg_write  = valid_m_i
                      & reg_write_m_i
                      & ~exc;
      wb_d.result_src = result_src_m_i;
      wb_d.read_data  = ext;
      wb_d.alu_result = alu_result_m_i;
      wb_d.rd_addr    = rd_addr_m_i;
      wb_d.pc_plus_4  = pc_plus_4_m_i;
      wb_d.exc        = exc;
      wb_d.cause      = cause;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      wb_q <= '0;
    else
      wb_q <= wb_d;
  end

  assign valid_w_o      = wb_q.valid;
  assign reg_write_w_o  = wb_q.reg_write;
  assign result_src_w_o = wb_q.result_src;
  assign read_data_w_o  = wb_q.read_data;
  assign alu_result_w_o = wb_q.alu_result;
  assign rd_addr_w_o    = wb_q.rd_addr;
  assign pc_plus_4_w_o  = wb_q.pc_plus_4;
  assign exc_w_o        = wb_q.exc;
  assign exc_cause_w_o  = wb_q.cause;

endmodule
